// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB memory completer: FSM state encodings,
// APB bus field widths and the index of the privileged bit in PPROT.
// No ports; imported by apb_mem_slave and apb_mem_slave_array.

package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int PROT_W = 3;

    // PPROT[0] set means a privileged access.
    localparam int PROT_PRIV = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : apb_pkg

// File: rtl/apb_mem_slave_array.sv
// apb_mem_slave_array
// 2**AW x 32-bit storage for the APB memory completer.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset; clears every word
//   wr_en    in   write this cycle
//   wr_idx   in   word index to write
//   wr_strb  in   byte lanes to update
//   wr_data  in   write data
//   rd_en    in   load rd_data from mem[rd_idx]; otherwise rd_data clears
//   rd_idx   in   word index to read
//   rd_data  out  registered read data

module apb_mem_slave_array
    import apb_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // The read register doubles as the bus read-data register: it only
    // holds a value in the cycle after rd_en, so it reads as zero whenever
    // the completer is not responding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule : apb_mem_slave_array

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB3/APB4 completer with a byte-writable word memory behind an address
// window [BASE_ADDR, BASE_ADDR + 4*2**AW - 1], WAIT_CYCLES wait states and
// slverr for misaligned or out-of-window accesses.
// Optional feature macro: APB_MEM_SLAVE_PROT_CHECK_EN -- when defined, writes
// with apb_prot_i[0]=0 are rejected with slverr; otherwise prot is ignored.
// Ports:
//   apb_clk_i     in   bus clock, rising edge
//   apb_resetn_i  in   asynchronous active-low reset
//   apb_addr_i    in   byte address
//   apb_sel_i     in   slave select
//   apb_enable_i  in   access phase
//   apb_write_i   in   1 = write
//   apb_strb_i    in   write byte strobes
//   apb_prot_i    in   protection attributes
//   apb_wdata_i   in   write data
//   apb_ready_o   out  transfer complete (registered)
//   apb_rdata_o   out  read data, 0 unless ready (registered)
//   apb_slverr_o  out  error response, 0 unless ready (registered)

module apb_mem_slave
    import apb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                AW          = 6,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              apb_clk_i,
    input  logic              apb_resetn_i,
    input  logic [ADDR_W-1:0] apb_addr_i,
    input  logic              apb_sel_i,
    input  logic              apb_enable_i,
    input  logic              apb_write_i,
    input  logic [STRB_W-1:0] apb_strb_i,
    input  logic [PROT_W-1:0] apb_prot_i,
    input  logic [DATA_W-1:0] apb_wdata_i,
    output logic              apb_ready_o,
    output logic [DATA_W-1:0] apb_rdata_o,
    output logic              apb_slverr_o
);

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;
    logic [AW-1:0]     idx_q;
    logic              write_q;
    logic [STRB_W-1:0] strb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              ready_q;
    logic              slverr_q;

    logic              setup;
    logic              misaligned;
    logic              in_window;
    logic              prot_err;
    logic              err_now;
    logic              enter_resp;
    logic              err_cur;
    logic              write_cur;
    logic [AW-1:0]     idx_cur;
    logic              rd_en;
    logic              wr_en;

    assign setup = apb_sel_i & ~apb_enable_i;

    // BASE_ADDR is aligned to the window size, so the window test reduces to
    // comparing the address bits above the word index.
    assign misaligned = |apb_addr_i[1:0];
    assign in_window  = (apb_addr_i[ADDR_W-1:AW+2] == BASE_ADDR[ADDR_W-1:AW+2]);

`ifdef APB_MEM_SLAVE_PROT_CHECK_EN
    logic unused_prot;
    assign unused_prot = ^apb_prot_i[PROT_W-1:1];
    assign prot_err    = apb_write_i & ~apb_prot_i[PROT_PRIV];
`else
    logic unused_prot;
    assign unused_prot = ^apb_prot_i;
    assign prot_err    = 1'b0;
`endif

    assign err_now = misaligned | ~in_window | prot_err;

    always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
        if (!apb_resetn_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping sel mid-transfer abandons it; the wait counter only runs while
    // the requester holds the access phase.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!apb_sel_i) begin
                    next_state = IDLE;
                end else if (apb_enable_i && (wait_cnt == 4'd0)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
        if (!apb_resetn_i) begin
            wait_cnt <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else if ((state == IDLE) && setup) begin
            wait_cnt <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            idx_q    <= apb_addr_i[AW+1:2];
            write_q  <= apb_write_i;
            strb_q   <= apb_strb_i;
            wdata_q  <= apb_wdata_i;
            err_q    <= err_now;
        end else if ((state == WAIT) && apb_sel_i && apb_enable_i &&
                     (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // With zero wait states the response is launched straight from the setup
    // edge, so the live bus decode is used instead of the captured copy.
    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign err_cur    = (state == IDLE) ? err_now              : err_q;
    assign write_cur  = (state == IDLE) ? apb_write_i          : write_q;
    assign idx_cur    = (state == IDLE) ? apb_addr_i[AW+1:2]   : idx_q;

    assign rd_en = enter_resp & ~write_cur & ~err_cur;
    assign wr_en = (state == RESP) & apb_sel_i & apb_enable_i & ready_q &
                   write_q & ~err_q;

    always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
        if (!apb_resetn_i) begin
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            ready_q  <= enter_resp;
            slverr_q <= enter_resp & err_cur;
        end
    end

    apb_mem_slave_array #(
        .AW (AW)
    ) u_array (
        .clk     (apb_clk_i),
        .rst_n   (apb_resetn_i),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_strb (strb_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (idx_cur),
        .rd_data (apb_rdata_o)
    );

    assign apb_ready_o  = ready_q;
    assign apb_slverr_o = slverr_q;

endmodule : apb_mem_slave

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave
// Directed bench for apb_mem_slave. Two instances share clock and reset:
// unit 0 with WAIT_CYCLES=0 at base 0, unit 1 with WAIT_CYCLES=3 at base
// 0x1000. Inputs are driven on the falling edge, outputs sampled there too.

module tb_apb_mem_slave;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          W0    = 0;
    localparam int          W1    = 3;

`ifdef APB_MEM_SLAVE_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] addr   [2];
    logic        sel    [2];
    logic        enable [2];
    logic        write  [2];
    logic [3:0]  strb   [2];
    logic [2:0]  prot   [2];
    logic [31:0] wdata  [2];
    logic        ready  [2];
    logic [31:0] rdata  [2];
    logic        slverr [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    apb_mem_slave #(
        .BASE_ADDR   (BASE0),
        .AW          (6),
        .WAIT_CYCLES (W0)
    ) dut0 (
        .apb_clk_i    (clock),
        .apb_resetn_i (reset_n),
        .apb_addr_i   (addr[0]),
        .apb_sel_i    (sel[0]),
        .apb_enable_i (enable[0]),
        .apb_write_i  (write[0]),
        .apb_strb_i   (strb[0]),
        .apb_prot_i   (prot[0]),
        .apb_wdata_i  (wdata[0]),
        .apb_ready_o  (ready[0]),
        .apb_rdata_o  (rdata[0]),
        .apb_slverr_o (slverr[0])
    );

    apb_mem_slave #(
        .BASE_ADDR   (BASE1),
        .AW          (6),
        .WAIT_CYCLES (W1)
    ) dut1 (
        .apb_clk_i    (clock),
        .apb_resetn_i (reset_n),
        .apb_addr_i   (addr[1]),
        .apb_sel_i    (sel[1]),
        .apb_enable_i (enable[1]),
        .apb_write_i  (write[1]),
        .apb_strb_i   (strb[1]),
        .apb_prot_i   (prot[1]),
        .apb_wdata_i  (wdata[1]),
        .apb_ready_o  (ready[1]),
        .apb_rdata_o  (rdata[1]),
        .apb_slverr_o (slverr[1])
    );

    function automatic int waitOf(input int u);
        return (u == 0) ? W0 : W1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drives one transfer and returns at the falling edge of the ready cycle,
    // leaving sel/enable high so a following call is back-to-back.
    task automatic applyStimulus(input int u, input logic wr,
                                 input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [2:0] p,
                                 output logic [31:0] rd, output logic err,
                                 output int lat);
        @(negedge clock);
        sel[u]    = 1'b1;
        enable[u] = 1'b0;
        write[u]  = wr;
        addr[u]   = a;
        strb[u]   = s;
        wdata[u]  = d;
        prot[u]   = p;
        @(negedge clock);
        enable[u] = 1'b1;
        lat = 1;
        while (ready[u] !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        rd  = rdata[u];
        err = slverr[u];
    endtask

    task automatic doWrite(input string tag, input int u, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           input logic [2:0] p, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(u, 1'b1, a, s, d, p, rd, err, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(1 + waitOf(u)));
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic doRead(input string tag, input int u, input logic [31:0] a,
                          input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(u, 1'b0, a, 4'h0, 32'h0, 3'b000, rd, err, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(1 + waitOf(u)));
        checkOutput({tag, "_data"}, rd, exp_data);
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic idleBus(input int u);
        @(negedge clock);
        sel[u]    = 1'b0;
        enable[u] = 1'b0;
        write[u]  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            addr[u] = '0; sel[u] = 1'b0; enable[u] = 1'b0; write[u] = 1'b0;
            strb[u] = '0; prot[u] = '0; wdata[u] = '0;
        end
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            checkOutput("reset_ready", 32'(ready[u]), 32'h0);
            checkOutput("reset_rdata", rdata[u], 32'h0);
            checkOutput("reset_slverr", 32'(slverr[u]), 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Zero wait states: write then back-to-back readback.
        doWrite("a_wr", 0, BASE0 + 32'h10, 4'hF, 32'hDEADBEEF, 3'b001, 1'b0);
        doRead("a_rd", 0, BASE0 + 32'h10, 32'hDEADBEEF, 1'b0);
        idleBus(0);

        // Three wait states: ready four cycles after setup, for one cycle.
        doRead("b_rd", 1, BASE1, 32'h0, 1'b0);
        idleBus(1);
        checkOutput("b_ready_one_cycle", 32'(ready[1]), 32'h0);

        // Byte strobes merge into the existing word.
        doWrite("c_wr1", 1, BASE1 + 32'h20, 4'hF, 32'h11223344, 3'b001, 1'b0);
        doWrite("c_wr2", 1, BASE1 + 32'h20, 4'b0101, 32'hAABBCCDD, 3'b001, 1'b0);
        doRead("c_rd", 1, BASE1 + 32'h20, 32'h11BB33DD, 1'b0);

        // Errors: 0x120 and misaligned 0x22 alias onto word 8 if undecoded.
        doWrite("d_wr_mis", 1, BASE1 + 32'h102, 4'hF, 32'hCAFEF00D, 3'b001, 1'b1);
        doRead("d_rd_oow", 1, BASE1 + 32'h100, 32'h0, 1'b1);
        doWrite("d_wr_oow", 1, BASE1 + 32'h120, 4'hF, 32'hFFFFFFFF, 3'b001, 1'b1);
        doWrite("d_wr_mis2", 1, BASE1 + 32'h22, 4'hF, 32'hFFFFFFFF, 3'b001, 1'b1);
        doRead("d_rd_mis", 1, BASE1 + 32'h22, 32'h0, 1'b1);
        doRead("d_rd_below", 1, BASE1 - 32'h4, 32'h0, 1'b1);
        doRead("d_rd_keep", 1, BASE1 + 32'h20, 32'h11BB33DD, 1'b0);
        doRead("d_rd_w0", 1, BASE1, 32'h0, 1'b0);
        doRead("d_rd_last", 1, BASE1 + 32'hFC, 32'h0, 1'b0);
        idleBus(1);

        // Abort a write by dropping sel during WAIT.
        @(negedge clock);
        sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1;
        addr[1] = BASE1 + 32'h30; strb[1] = 4'hF; wdata[1] = 32'h99999999;
        @(negedge clock);
        enable[1] = 1'b1;
        @(negedge clock);
        checkOutput("e_abort_ready", 32'(ready[1]), 32'h0);
        sel[1] = 1'b0; enable[1] = 1'b0;
        doWrite("e_wr", 1, BASE1 + 32'h34, 4'hF, 32'h12345678, 3'b001, 1'b0);
        doRead("e_rd_abort", 1, BASE1 + 32'h30, 32'h0, 1'b0);
        doRead("e_rd", 1, BASE1 + 32'h34, 32'h12345678, 1'b0);
        idleBus(1);

        // Unprivileged write is rejected only when the prot check is built in.
        doWrite("p_wr_user", 0, BASE0 + 32'h40, 4'hF, 32'hA5A5A5A5, 3'b000, PROT_EN);
        doRead("p_rd_user", 0, BASE0 + 32'h40,
               PROT_EN ? 32'h0 : 32'hA5A5A5A5, 1'b0);
        doWrite("p_wr_priv", 0, BASE0 + 32'h44, 4'hF, 32'h5A5A5A5A, 3'b001, 1'b0);
        doRead("p_rd_priv", 0, BASE0 + 32'h44, 32'h5A5A5A5A, 1'b0);

        // Reset while a read response is on the bus clears it immediately.
        doWrite("g_wr", 0, BASE0 + 32'h60, 4'hF, 32'h0F0F0F0F, 3'b001, 1'b0);
        @(negedge clock);
        sel[0] = 1'b1; enable[0] = 1'b0; write[0] = 1'b0; addr[0] = BASE0 + 32'h60;
        @(negedge clock);
        enable[0] = 1'b1;
        checkOutput("g_ready", 32'(ready[0]), 32'h1);
        checkOutput("g_rdata", rdata[0], 32'h0F0F0F0F);
        reset_n = 1'b0;
        #1;
        checkOutput("g_rst_ready", 32'(ready[0]), 32'h0);
        checkOutput("g_rst_rdata", rdata[0], 32'h0);
        sel[0] = 1'b0; enable[0] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Reset during the WAIT cycle of a write drops the write.
        doWrite("f_pre", 1, BASE1 + 32'h54, 4'hF, 32'h13572468, 3'b001, 1'b0);
        idleBus(1);
        @(negedge clock);
        sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1;
        addr[1] = BASE1 + 32'h50; strb[1] = 4'hF; wdata[1] = 32'h77777777;
        @(negedge clock);
        enable[1] = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("f_rst_ready", 32'(ready[1]), 32'h0);
        checkOutput("f_rst_slverr", 32'(slverr[1]), 32'h0);
        checkOutput("f_rst_rdata", rdata[1], 32'h0);
        sel[1] = 1'b0; enable[1] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        doRead("f_rd_50", 1, BASE1 + 32'h50, 32'h0, 1'b0);
        doRead("f_rd_54", 1, BASE1 + 32'h54, 32'h0, 1'b0);
        idleBus(1);
        doRead("f_rd_dut0", 0, BASE0 + 32'h10, 32'h0, 1'b0);
        idleBus(0);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_mem_slave
